// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl: match-level sequencer for VGA Pong.
// Tracks both scores and walks the match through IDLE, SERVE, PLAY, POINT and OVER.
// Every output is registered and is driven from the next-state values.
module pong_match_ctrl #(
  parameter int WIN_SCORE    = 7,   // 1..15
  parameter int SERVE_FRAMES = 60,  // 1..255
  parameter int POINT_FRAMES = 90   // 1..255
) (
  input  logic       vga_clk,
  input  logic       rst,
  input  logic       start,
  input  logic       vs_in,
  input  logic       p1_win,
  input  logic       p2_win,
  output logic       ball_rst,
  output logic       paddle_rst,
  output logic       play_en,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic [2:0] state,
  output logic       game_over,
  output logic [1:0] winner
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_t;

  localparam logic [3:0] WIN_S     = 4'(WIN_SCORE);
  localparam logic [7:0] SERVE_END = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0] POINT_END = 8'(POINT_FRAMES - 1);

  // A score is capped at WIN_SCORE, so the 4-bit add never wraps.
  function automatic logic [3:0] inc_score(input logic [3:0] s);
    inc_score = (s >= WIN_S) ? WIN_S : s + 4'd1;
  endfunction

  state_t     state_q, state_d;
  logic [3:0] p1_q, p1_d, p2_q, p2_d;
  logic [1:0] winner_q, winner_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       sync1_q, sync2_q, sync3_q, start_pulse_q;
  logic       vs_q;
  logic       ball_rst_q, paddle_rst_q, play_en_q, game_over_q;
  logic       frame_tick;

  // Falling edge of the active-low vertical sync, once per frame.
  assign frame_tick = vs_q & ~vs_in;

  // Next-state, score and frame-counter logic.
  always_comb begin
    state_d  = state_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    winner_d = winner_q;
    case (state_q)
      IDLE, OVER: begin
        if (start_pulse_q) begin
          p1_d     = 4'd0;
          p2_d     = 4'd0;
          winner_d = 2'b00;
          state_d  = SERVE;
        end
      end
      SERVE: begin
        if (frame_tick && frame_cnt_q == SERVE_END) state_d = PLAY;
      end
      PLAY: begin
        if (p1_win && p2_win) begin
          // Simultaneous exits count as a replay with no score change.
          state_d = POINT;
        end else if (p1_win) begin
          p1_d = inc_score(p1_q);
          if (p1_d == WIN_S) begin
            state_d  = OVER;
            winner_d = 2'b01;
          end else begin
            state_d = POINT;
          end
        end else if (p2_win) begin
          p2_d = inc_score(p2_q);
          if (p2_d == WIN_S) begin
            state_d  = OVER;
            winner_d = 2'b10;
          end else begin
            state_d = POINT;
          end
        end
      end
      POINT: begin
        if (frame_tick && frame_cnt_q == POINT_END) state_d = SERVE;
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q)
      frame_cnt_d = 8'd0;
    else if (frame_tick)
      frame_cnt_d = frame_cnt_q + 8'd1;
    else
      frame_cnt_d = frame_cnt_q;
  end

  // State, counters, synchronisers and registered outputs.
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      state_q       <= IDLE;
      p1_q          <= 4'd0;
      p2_q          <= 4'd0;
      winner_q      <= 2'b00;
      frame_cnt_q   <= 8'd0;
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      sync3_q       <= 1'b0;
      start_pulse_q <= 1'b0;
      vs_q          <= 1'b1;
      ball_rst_q    <= 1'b1;
      paddle_rst_q  <= 1'b1;
      play_en_q     <= 1'b0;
      game_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      p1_q          <= p1_d;
      p2_q          <= p2_d;
      winner_q      <= winner_d;
      frame_cnt_q   <= frame_cnt_d;
      sync1_q       <= start;
      sync2_q       <= sync1_q;
      sync3_q       <= sync2_q;
      start_pulse_q <= sync2_q & ~sync3_q;
      vs_q          <= vs_in;
      ball_rst_q    <= (state_d != PLAY);
      paddle_rst_q  <= (state_d == IDLE);
      play_en_q     <= (state_d == PLAY);
      game_over_q   <= (state_d == OVER);
    end
  end

  assign ball_rst   = ball_rst_q;
  assign paddle_rst = paddle_rst_q;
  assign play_en    = play_en_q;
  assign p1_score   = p1_q;
  assign p2_score   = p2_q;
  assign state      = state_q;
  assign game_over  = game_over_q;
  assign winner     = winner_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed bench for pong_match_ctrl with WIN_SCORE=3, SERVE_FRAMES=2, POINT_FRAMES=2.
module tb_pong_match_ctrl;

  logic       vga_clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       vs_in = 1'b1;
  logic       p1_win = 1'b0;
  logic       p2_win = 1'b0;
  logic       ball_rst, paddle_rst, play_en, game_over;
  logic [3:0] p1_score, p2_score;
  logic [2:0] state;
  logic [1:0] winner;

  int n_chk  = 0;
  int n_pass = 0;

  pong_match_ctrl #(.WIN_SCORE(3), .SERVE_FRAMES(2), .POINT_FRAMES(2)) dut (
    .vga_clk(vga_clk), .rst(rst), .start(start), .vs_in(vs_in),
    .p1_win(p1_win), .p2_win(p2_win), .ball_rst(ball_rst),
    .paddle_rst(paddle_rst), .play_en(play_en), .p1_score(p1_score),
    .p2_score(p2_score), .state(state), .game_over(game_over), .winner(winner)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  // One full sync period: the low cycle produces the frame tick.
  task automatic frame();
    vs_in = 1'b0;
    step();
    vs_in = 1'b1;
    step();
  endtask

  // Hold start for four edges; state changes on the fourth.
  task automatic press_start();
    start = 1'b1;
    repeat (4) step();
    start = 1'b0;
  endtask

  initial begin
    // Reset
    step();
    rst = 1'b0;
    chk("rst_state", 8'(state), 8'd0);
    chk("rst_ball", 8'(ball_rst), 8'd1);
    chk("rst_paddle", 8'(paddle_rst), 8'd1);
    chk("rst_play", 8'(play_en), 8'd0);
    chk("rst_over", 8'(game_over), 8'd0);
    chk("rst_scores", {p1_score, p2_score}, 8'h00);
    chk("rst_winner", 8'(winner), 8'd0);

    // Start latency: still IDLE after 3 edges, SERVE on the 4th
    start = 1'b1;
    repeat (3) step();
    chk("start_lat3", 8'(state), 8'd0);
    step();
    start = 1'b0;
    chk("start_serve", 8'(state), 8'd1);
    chk("serve_paddle", 8'(paddle_rst), 8'd0);
    chk("serve_ball", 8'(ball_rst), 8'd1);

    // Serve: first tick keeps SERVE, second tick releases the ball
    frame();
    chk("serve_1tick", 8'(state), 8'd1);
    chk("serve_1ball", 8'(ball_rst), 8'd1);
    vs_in = 1'b0;
    step();
    chk("serve_play", 8'(state), 8'd2);
    chk("serve_ballfall", 8'(ball_rst), 8'd0);
    chk("serve_playen", 8'(play_en), 8'd1);
    vs_in = 1'b1;
    step();

    // p1_win held 5 cycles scores exactly once
    p1_win = 1'b1;
    step();
    chk("p1_score1", 8'(p1_score), 8'd1);
    chk("p1_point", 8'(state), 8'd3);
    chk("p1_ballrst", 8'(ball_rst), 8'd1);
    repeat (4) step();
    p1_win = 1'b0;
    chk("p1_once", 8'(p1_score), 8'd1);
    chk("p1_stay_pt", 8'(state), 8'd3);
    frame();
    chk("point_1tick", 8'(state), 8'd3);
    frame();
    chk("point_serve", 8'(state), 8'd1);
    repeat (2) frame();
    chk("reserve_play", 8'(state), 8'd2);

    // Both win inputs together: replay
    p1_win = 1'b1;
    p2_win = 1'b1;
    step();
    p1_win = 1'b0;
    p2_win = 1'b0;
    chk("both_state", 8'(state), 8'd3);
    chk("both_scores", {p1_score, p2_score}, 8'h10);
    repeat (4) frame();
    chk("both_back", 8'(state), 8'd2);

    // Start ignored during PLAY
    press_start();
    step();
    chk("start_in_play", 8'(state), 8'd2);

    // Player 2 wins three points
    for (int i = 0; i < 3; i++) begin
      p2_win = 1'b1;
      step();
      p2_win = 1'b0;
      if (i < 2) begin
        chk("p2_pt_state", 8'(state), 8'd3);
        repeat (4) frame();
      end
    end
    chk("over_state", 8'(state), 8'd4);
    chk("over_flag", 8'(game_over), 8'd1);
    chk("over_winner", 8'(winner), 8'd2);
    chk("over_scores", {p1_score, p2_score}, 8'h13);
    p1_win = 1'b1;
    step();
    p2_win = 1'b1;
    repeat (2) step();
    p1_win = 1'b0;
    p2_win = 1'b0;
    chk("over_frozen", {p1_score, p2_score}, 8'h13);
    chk("over_hold", 8'(state), 8'd4);

    // Restart from OVER
    press_start();
    chk("restart_state", 8'(state), 8'd1);
    chk("restart_scores", {p1_score, p2_score}, 8'h00);
    chk("restart_winner", 8'(winner), 8'd0);
    chk("restart_over", 8'(game_over), 8'd0);

    // Reach PLAY with p1_score = 2, then reset
    repeat (2) frame();
    for (int i = 0; i < 2; i++) begin
      p1_win = 1'b1;
      step();
      p1_win = 1'b0;
      repeat (4) frame();
    end
    chk("pre_rst_play", 8'(state), 8'd2);
    chk("pre_rst_p1", 8'(p1_score), 8'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_state", 8'(state), 8'd0);
    chk("mid_rst_scores", {p1_score, p2_score}, 8'h00);
    chk("mid_rst_ball", 8'(ball_rst), 8'd1);
    chk("mid_rst_paddle", 8'(paddle_rst), 8'd1);
    chk("mid_rst_play", 8'(play_en), 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
